usart_rx_shift_register: RTL

//  USART receiver front end: synchronises RXD, detects start bits, oversamples with
//  3-sample majority vote, deserialises 5..9 data bits LSB first, checks parity and stop.

---
 rtl/usart_rx_shift_register_pkg.sv | 37 +++
 rtl/usart_rx_sampler.sv | 39 +++
 rtl/usart_rx_shift_register.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/usart_rx_shift_register_pkg.sv
// Shared USART receiver definitions: frame format encodings, receiver FSM states
// and oversampling ratios.
package usart_defines;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  localparam logic [2:0] UCSZ_5 = 3'b000;
  localparam logic [2:0] UCSZ_6 = 3'b001;
  localparam logic [2:0] UCSZ_7 = 3'b010;
  localparam logic [2:0] UCSZ_8 = 3'b011;
  localparam logic [2:0] UCSZ_9 = 3'b111;

  localparam logic [1:0] UPM_OFF  = 2'b00;
  localparam logic [1:0] UPM_EVEN = 2'b10;
  localparam logic [1:0] UPM_ODD  = 2'b11;

  localparam logic [4:0] OVS_NORMAL = 5'd16;
  localparam logic [4:0] OVS_DOUBLE = 5'd8;

  // Undefined size codes fall back to 8 data bits.
  function automatic logic [3:0] char_bits(input logic [2:0] ucsz);
    case (ucsz)
      UCSZ_5:  char_bits = 4'd5;
      UCSZ_6:  char_bits = 4'd6;
      UCSZ_7:  char_bits = 4'd7;
      UCSZ_9:  char_bits = 4'd9;
      default: char_bits = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/usart_rx_sampler.sv
// RXD synchroniser plus three-sample majority voter; the vote is flagged valid
// the cycle after the last of the three samples has been captured.
module usart_rx_sampler #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rxd,
  input  logic i_sample,
  input  logic i_last_sample,
  output logic rxd_sync,
  output logic voted,
  output logic voted_valid
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [2:0]             samples_reg;
  logic                   voted_valid_reg;

  // Synchroniser idles high so reset never looks like a start bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_reg        <= '1;
      samples_reg     <= 3'b000;
      voted_valid_reg <= 1'b0;
    end else begin
      sync_reg        <= {sync_reg[SYNC_STAGES-2:0], i_rxd};
      voted_valid_reg <= i_last_sample;
      if (i_sample) samples_reg <= {samples_reg[1:0], sync_reg[SYNC_STAGES-1]};
    end
  end

  assign rxd_sync    = sync_reg[SYNC_STAGES-1];
  assign voted       = (samples_reg[0] & samples_reg[1]) |
                       (samples_reg[0] & samples_reg[2]) |
                       (samples_reg[1] & samples_reg[2]);
  assign voted_valid = voted_valid_reg;

endmodule

// File: rtl/usart_rx_shift_register.sv
// USART receive front end: start detection, oversampled bit recovery, character
// assembly with parity/stop checking, and a held output character for the buffer.
module usart_rx_shift_register
  import usart_defines::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_baud_tick,
  input  logic       i_rxd,
  input  logic       i_rx_enable,
  input  logic       i_double_speed,
  input  logic [2:0] i_char_size,
  input  logic [1:0] i_parity_mode,
  input  logic       i_rx_buffer_full,
  output logic [8:0] o_shift_register,
  output logic       o_shift_register_valid,
  output logic       o_frame_error,
  output logic       o_parity_error,
  output logic       o_data_overrun
);

  rx_state_t  state_reg, state_next;
  logic [4:0] tick_cnt_reg, tick_cnt_next, ovs, half;
  logic [3:0] nbits_reg, bit_cnt_reg;
  logic [8:0] asm_reg;
  logic       ds_reg, parity_on_reg, parity_odd_reg, xor_reg, pe_pend_reg, armed_reg;
  logic       sample, last_sample, rxd_sync, voted, voted_valid;
  logic       start_detect, start_confirm, data_bit, parity_bit, frame_done;

  usart_rx_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_sampler (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_rxd         (i_rxd),
    .i_sample      (sample),
    .i_last_sample (last_sample),
    .rxd_sync      (rxd_sync),
    .voted         (voted),
    .voted_valid   (voted_valid)
  );

  // Tick counter runs 1..OVS per bit, continuously from the detected start edge.
  assign ovs           = ds_reg ? OVS_DOUBLE : OVS_NORMAL;
  assign half          = ovs >> 1;
  assign tick_cnt_next = (tick_cnt_reg >= ovs) ? 5'd1 : tick_cnt_reg + 5'd1;
  assign sample        = i_baud_tick && i_rx_enable && (state_reg != RX_IDLE) &&
                         (tick_cnt_next >= half) && (tick_cnt_next <= half + 5'd2);
  assign last_sample   = sample && (tick_cnt_next == half + 5'd2);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_reg <= RX_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    start_detect  = 1'b0;
    start_confirm = 1'b0;
    data_bit      = 1'b0;
    parity_bit    = 1'b0;
    frame_done    = 1'b0;
    if (!i_rx_enable) begin
      state_next = RX_IDLE;
    end else begin
      case (state_reg)
        RX_IDLE: if (i_baud_tick && !rxd_sync && armed_reg) begin
          start_detect = 1'b1;
          state_next   = RX_START;
        end
        RX_START: if (voted_valid) begin
          if (voted) begin
            state_next = RX_IDLE;
          end else begin
            start_confirm = 1'b1;
            state_next    = RX_DATA;
          end
        end
        RX_DATA: if (voted_valid) begin
          data_bit = 1'b1;
          if (bit_cnt_reg == nbits_reg - 4'd1)
            state_next = parity_on_reg ? RX_PARITY : RX_STOP;
        end
        RX_PARITY: if (voted_valid) begin
          parity_bit = 1'b1;
          state_next = RX_STOP;
        end
        RX_STOP: if (voted_valid) begin
          frame_done = 1'b1;
          state_next = RX_IDLE;
        end
        default: state_next = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tick_cnt_reg           <= 5'd0;
      bit_cnt_reg            <= 4'd0;
      nbits_reg              <= 4'd8;
      asm_reg                <= 9'd0;
      ds_reg                 <= 1'b0;
      parity_on_reg          <= 1'b0;
      parity_odd_reg         <= 1'b0;
      xor_reg                <= 1'b0;
      pe_pend_reg            <= 1'b0;
      armed_reg              <= 1'b1;
      o_shift_register       <= 9'd0;
      o_shift_register_valid <= 1'b0;
      o_frame_error          <= 1'b0;
      o_parity_error         <= 1'b0;
      o_data_overrun         <= 1'b0;
    end else begin
      if (start_detect) begin
        tick_cnt_reg <= 5'd1;
        ds_reg       <= i_double_speed;
      end else if (i_baud_tick && state_reg != RX_IDLE) begin
        tick_cnt_reg <= tick_cnt_next;
      end
      if (start_confirm) begin
        nbits_reg              <= char_bits(i_char_size);
        parity_on_reg          <= i_parity_mode[1];
        parity_odd_reg         <= i_parity_mode[0];
        asm_reg                <= 9'd0;
        bit_cnt_reg            <= 4'd0;
        xor_reg                <= 1'b0;
        pe_pend_reg            <= 1'b0;
        o_data_overrun         <= o_shift_register_valid & i_rx_buffer_full;
        o_shift_register_valid <= 1'b0;
      end
      if (data_bit) begin
        asm_reg[bit_cnt_reg] <= voted;
        bit_cnt_reg          <= bit_cnt_reg + 4'd1;
        xor_reg              <= xor_reg ^ voted;
      end
      if (parity_bit) pe_pend_reg <= parity_odd_reg ? ~(xor_reg ^ voted) : (xor_reg ^ voted);
      // After a break the line must return high before another start is accepted.
      if (rxd_sync) armed_reg <= 1'b1;
      if (frame_done) begin
        o_shift_register       <= asm_reg;
        o_frame_error          <= ~voted;
        o_parity_error         <= pe_pend_reg;
        o_shift_register_valid <= 1'b1;
        armed_reg              <= 1'b0;
      end
      if (!i_rx_enable) begin
        o_shift_register_valid <= 1'b0;
        o_data_overrun         <= 1'b0;
      end
    end
  end

endmodule
